// File: rtl/pyramid_pulse_checker.sv
// Receiver-side monitor for the pyramid counter: measures row gaps, checks the descending sequence, flags violations.
// Optional macro PYRAMID_CHECKER_STALL_EN adds a 'stall' output that drops lock after a long enable-low period.
module pyramid_pulse_checker #(
    parameter int W         = 4,
    parameter int MAX_START = 15,
    parameter int MIN_ROW   = 1,
    parameter int ERR_W     = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             pulse1,
    input  logic             pulse2,
    output logic [W-1:0]     row_len,
    output logic [W-1:0]     row_idx,
    output logic             row_valid,
    output logic             pyramid_done,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
`ifdef PYRAMID_CHECKER_STALL_EN
    ,
    output logic             stall
`endif
);

    localparam logic             ST_SYNC   = 1'b0;
    localparam logic             ST_TRACK  = 1'b1;
    localparam logic [W:0]       GAP_MAX   = '1;
    localparam logic [W:0]       GAP_LIMIT = (W+1)'(MAX_START + 1);
    localparam logic [W:0]       GAP_ONE   = (W+1)'(1);
    localparam logic [W-1:0]     EXP_START = W'(MAX_START);
    localparam logic [W-1:0]     EXP_LAST  = W'(MIN_ROW);
    localparam logic [W-1:0]     IDX_ONE   = W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    logic         state;
    logic [W:0]   gap;
    logic [W-1:0] exp_len;
    logic [W-1:0] idx;
    logic         sync_hit;
    logic         row_hit;
    logic         last_row;
    logic         row_ok;
    logic         err_event;
    logic         stall_hit;

    // All violations of one active cycle collapse into a single error event.
    always_comb begin
        last_row  = (exp_len == EXP_LAST);
        row_ok    = (gap == {1'b0, exp_len}) && (pulse2 == last_row);
        sync_hit  = enable && (state == ST_SYNC) && pulse1 && pulse2;
        row_hit   = enable && (state == ST_TRACK) && pulse1;
        err_event = enable && (state == ST_TRACK) &&
                    (pulse1 ? !row_ok : (pulse2 || (gap == GAP_LIMIT)));
    end

`ifdef PYRAMID_CHECKER_STALL_EN
    localparam logic [W+2:0] STALL_LIMIT = (W+3)'(4 * (MAX_START + 1));
    logic [W+1:0] idle;
    logic [W+2:0] idle_next;

    always_comb begin
        idle_next = {1'b0, idle} + (W+3)'(1);
        stall_hit = !enable && (state == ST_TRACK) && (idle_next == STALL_LIMIT);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            idle  <= '0;
            stall <= 1'b0;
        end else if (enable) begin
            idle  <= '0;
            stall <= 1'b0;
        end else if (state == ST_TRACK) begin
            if (stall_hit) begin
                idle  <= '0;
                stall <= 1'b1;
            end else begin
                idle <= idle_next[W+1:0];
            end
        end
    end
`else
    always_comb stall_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= ST_SYNC;
            exp_len <= EXP_START;
            idx     <= '0;
        end else if (sync_hit) begin
            state   <= ST_TRACK;
            exp_len <= EXP_START;
            idx     <= '0;
        end else if (err_event || stall_hit) begin
            state <= ST_SYNC;
        end else if (row_hit) begin
            if (last_row) begin
                exp_len <= EXP_START;
                idx     <= '0;
            end else begin
                exp_len <= exp_len - IDX_ONE;
                idx     <= idx + IDX_ONE;
            end
        end
    end

    // Gap keeps running in SYNC too, so a relock pulse always starts the next row from zero.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            gap <= '0;
        end else if (enable) begin
            if (pulse1) begin
                gap <= '0;
            end else if (gap != GAP_MAX) begin
                gap <= gap + GAP_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            row_len      <= '0;
            row_idx      <= '0;
            row_valid    <= 1'b0;
            pyramid_done <= 1'b0;
            err          <= 1'b0;
            err_count    <= '0;
        end else begin
            row_valid    <= row_hit;
            pyramid_done <= row_hit && row_ok && last_row;
            if (row_hit) begin
                row_len <= gap[W-1:0];
                row_idx <= idx;
            end
            if (err_event) begin
                err <= 1'b1;
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_ONE;
                end
            end
        end
    end

    assign locked = (state == ST_TRACK);

endmodule

// File: tb/tb_pyramid_pulse_checker.sv
// Self-checking bench for pyramid_pulse_checker: scripted producer streams plus a randomized
// stream, checked against a row-arithmetic reference model of the pulse protocol.
module tb_pyramid_pulse_checker;

    localparam int W         = 4;
    localparam int MAX_START = 15;
    localparam int MIN_ROW   = 1;
    localparam int ERR_W     = 8;

    logic             clock   = 1'b0;
    logic             clear_n = 1'b1;
    logic             enable  = 1'b0;
    logic             pulse1  = 1'b0;
    logic             pulse2  = 1'b0;
    logic [W-1:0]     row_len;
    logic [W-1:0]     row_idx;
    logic             row_valid;
    logic             pyramid_done;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
`ifdef PYRAMID_CHECKER_STALL_EN
    logic             stall;
`endif

    pyramid_pulse_checker #(
        .W(W), .MAX_START(MAX_START), .MIN_ROW(MIN_ROW), .ERR_W(ERR_W)
    ) dut (
        .clock(clock),
        .clear_n(clear_n),
        .enable(enable),
        .pulse1(pulse1),
        .pulse2(pulse2),
        .row_len(row_len),
        .row_idx(row_idx),
        .row_valid(row_valid),
        .pyramid_done(pyramid_done),
        .locked(locked),
        .err(err),
        .err_count(err_count)
`ifdef PYRAMID_CHECKER_STALL_EN
        ,
        .stall(stall)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: protocol position expressed as row number within the pyramid.
    bit m_locked, m_err, m_rv, m_pd;
    int m_row, m_gap, m_errs, m_len, m_ridx;

    int          obs_n, exp_n, obs_pd, exp_pd;
    int unsigned obs_sig, exp_sig;
    logic [7:0]  obs_last;
    bit          toggle_en;
    int          tog_cnt;

    function automatic logic [19:0] dut_vec();
        return {row_valid, row_len, row_idx, pyramid_done, locked, err, err_count};
    endfunction

    function automatic logic [19:0] model_vec();
        int sat;
        sat = (m_errs > 255) ? 255 : m_errs;
        return {m_rv, 4'(m_len), 4'(m_ridx), m_pd, m_locked, m_err, 8'(sat)};
    endfunction

    function automatic int unsigned clean_sig();
        int unsigned s;
        s = 0;
        for (int r = 0; r < 15; r++) s = s * 33 + 32'((15 - r) * 16 + r);
        return s;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_rv = 0; m_pd = 0;
        m_row = 0; m_gap = 0; m_errs = 0; m_len = 0; m_ridx = 0;
    endtask

    task automatic model_step(input bit en, input bit p1, input bit p2);
        int  want;
        bit  last;
        bit  bad;
        m_rv = 0;
        m_pd = 0;
        if (en) begin
            want = MAX_START - m_row;
            last = (want == MIN_ROW);
            bad  = 0;
            if (!m_locked) begin
                if (p1 && p2) begin
                    m_locked = 1;
                    m_row    = 0;
                end
            end else if (p1) begin
                m_rv   = 1;
                m_len  = m_gap % 16;
                m_ridx = m_row;
                if (m_gap == want && p2 == last) begin
                    if (last) begin
                        m_pd  = 1;
                        m_row = 0;
                    end else begin
                        m_row++;
                    end
                end else begin
                    bad = 1;
                end
            end else if (p2 || m_gap == MAX_START + 1) begin
                bad = 1;
            end
            if (bad) begin
                m_err    = 1;
                m_errs++;
                m_locked = 0;
            end
            m_gap = p1 ? 0 : ((m_gap < 31) ? m_gap + 1 : 31);
        end
    endtask

    task automatic clear_log();
        obs_n = 0; exp_n = 0; obs_pd = 0; exp_pd = 0;
        obs_sig = 0; exp_sig = 0; obs_last = 8'h00;
    endtask

    task automatic applyStimulus(input bit en, input bit p1, input bit p2);
        enable = en;
        pulse1 = p1;
        pulse2 = p2;
        @(posedge clock);
        model_step(en, p1, p2);
        #1;
        if (row_valid === 1'b1) begin
            obs_n++;
            obs_sig  = obs_sig * 33 + 32'({row_len, row_idx});
            obs_last = {row_len, row_idx};
        end
        if (pyramid_done === 1'b1) obs_pd++;
        if (m_rv) begin
            exp_n++;
            exp_sig = exp_sig * 33 + 32'(m_len * 16 + m_ridx);
        end
        if (m_pd) exp_pd++;
    endtask

    task automatic active_cycle(input bit p1, input bit p2);
        if (toggle_en) begin
            if (tog_cnt == 2) begin
                applyStimulus(1'b0, 1'($urandom), 1'($urandom));
                tog_cnt = 0;
            end else begin
                tog_cnt++;
            end
        end
        applyStimulus(1'b1, p1, p2);
    endtask

    task automatic send_row(input int len, input bit p2);
        repeat (len) active_cycle(1'b0, 1'b0);
        active_cycle(1'b1, p2);
    endtask

    task automatic send_rows(input int first, input int last);
        for (int r = first; r <= last; r++) send_row(MAX_START - r, (MAX_START - r) == MIN_ROW);
    endtask

    task automatic do_reset();
        #2;
        clear_n = 1'b0;
        enable  = 1'b0;
        pulse1  = 1'b0;
        pulse2  = 1'b0;
        model_reset();
        tog_cnt = 0;
        @(posedge clock);
        #1;
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 clear_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", dut_vec(), 20'h0);
        end
        @(posedge clock);
        #1 clear_n = 1'b1;
        clear_log();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL sync_ignores_pulse2: got locked=%b err=%b expected 0 0", locked, err);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("[TB] FAIL post_reset_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_clean();
        do_reset();
        clear_log();
        active_cycle(1'b1, 1'b1);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("[TB] FAIL clean_lock: got %b expected 1", locked);
        end
        send_rows(0, 14);
        checks++;
        if (obs_n !== 15 || obs_pd !== 1) begin
            errors++; $display("[TB] FAIL clean_counts: got rows=%0d done=%0d expected 15 1", obs_n, obs_pd);
        end
        checks++;
        if (obs_sig !== clean_sig() || obs_sig !== exp_sig) begin
            errors++; $display("[TB] FAIL clean_rows: got %h expected %h", obs_sig, clean_sig());
        end
        checks++;
        if (obs_last !== 8'h1E) begin
            errors++; $display("[TB] FAIL clean_last_row: got %h expected 1e", obs_last);
        end
        checks++;
        if (err !== 1'b0 || locked !== 1'b1) begin
            errors++; $display("[TB] FAIL clean_status: got err=%b locked=%b expected 0 1", err, locked);
        end
    endtask

    task automatic test_enable_toggle();
        do_reset();
        clear_log();
        toggle_en = 1;
        active_cycle(1'b1, 1'b1);
        send_rows(0, 14);
        toggle_en = 0;
        checks++;
        if (obs_n !== 15 || obs_pd !== 1) begin
            errors++; $display("[TB] FAIL toggle_counts: got rows=%0d done=%0d expected 15 1", obs_n, obs_pd);
        end
        checks++;
        if (obs_sig !== clean_sig() || obs_sig !== exp_sig) begin
            errors++; $display("[TB] FAIL toggle_rows: got %h expected %h", obs_sig, clean_sig());
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("[TB] FAIL toggle_err: got %b expected 0", err);
        end
    endtask

    task automatic test_short_row();
        do_reset();
        clear_log();
        active_cycle(1'b1, 1'b1);
        send_rows(0, 2);
        send_row(11, 1'b0);
        checks++;
        if (obs_last !== 8'hB3) begin
            errors++; $display("[TB] FAIL short_row_strobe: got %h expected b3", obs_last);
        end
        checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL short_row_error: got err=%b count=%0d locked=%b expected 1 1 0",
                               err, err_count, locked);
        end
        send_rows(4, 14);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            errors++; $display("[TB] FAIL short_row_relock: got locked=%b count=%0d expected 1 1", locked, err_count);
        end
        clear_log();
        send_rows(0, 14);
        checks++;
        if (obs_n !== 15 || obs_pd !== 1 || obs_sig !== clean_sig()) begin
            errors++; $display("[TB] FAIL short_row_next_pyramid: got rows=%0d done=%0d sig=%h expected 15 1 %h",
                               obs_n, obs_pd, obs_sig, clean_sig());
        end
        checks++;
        if (err_count !== 8'd1) begin
            errors++; $display("[TB] FAIL short_row_count_held: got %0d expected 1", err_count);
        end
    endtask

    task automatic test_bad_pulse2();
        do_reset();
        clear_log();
        active_cycle(1'b1, 1'b1);
        send_rows(0, 12);
        send_row(2, 1'b1);
        checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL early_pulse2_error: got err=%b count=%0d locked=%b expected 1 1 0",
                               err, err_count, locked);
        end
        checks++;
        if (obs_pd !== 0 || obs_n !== 14) begin
            errors++; $display("[TB] FAIL early_pulse2_strobes: got done=%0d rows=%0d expected 0 14", obs_pd, obs_n);
        end
    endtask

    task automatic test_gap_overflow();
        do_reset();
        clear_log();
        active_cycle(1'b1, 1'b1);
        repeat (16) active_cycle(1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || locked !== 1'b1) begin
            errors++; $display("[TB] FAIL gap16_no_error_yet: got err=%b locked=%b expected 0 1", err, locked);
        end
        active_cycle(1'b0, 1'b0);
        checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL gap_overflow: got err=%b count=%0d locked=%b expected 1 1 0",
                               err, err_count, locked);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("[TB] FAIL gap_overflow_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_log();
        active_cycle(1'b1, 1'b1);
        send_rows(0, 6);
        repeat (4) active_cycle(1'b0, 1'b0);
        #2 clear_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++; $display("[TB] FAIL mid_reset_immediate: got %h expected %h", dut_vec(), 20'h0);
        end
        enable = 1'b1; pulse1 = 1'b1; pulse2 = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++; $display("[TB] FAIL mid_reset_held: got %h expected %h", dut_vec(), 20'h0);
        end
        clear_n = 1'b1;
        clear_log();
        send_row(5, 1'b0);
        send_row(4, 1'b0);
        checks++;
        if (obs_n !== 0 || obs_pd !== 0 || locked !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_no_strobes: got rows=%0d done=%0d locked=%b expected 0 0 0",
                               obs_n, obs_pd, locked);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("[TB] FAIL mid_reset_state: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        clear_log();
        repeat (100) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b1);
        end
        checks++;
        if (err_count !== 8'd100) begin
            errors++; $display("[TB] FAIL err_count_100: got %0d expected 100", err_count);
        end
        repeat (200) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b1);
        end
        checks++;
        if (err_count !== 8'd255 || err !== 1'b1) begin
            errors++; $display("[TB] FAIL err_count_saturate: got count=%0d err=%b expected 255 1", err_count, err);
        end
        checks++;
        if (obs_n !== 300 || obs_sig !== exp_sig) begin
            errors++; $display("[TB] FAIL saturation_rows: got rows=%0d sig=%h expected 300 %h", obs_n, obs_sig, exp_sig);
        end
    endtask

    task automatic test_random();
        logic [1:0] plan[$];
        int         len;
        bit         p2;
        do_reset();
        clear_log();
        plan.push_back(2'b11);
        for (int p = 0; p < 8; p++) begin
            for (int r = 0; r < 15; r++) begin
                len = MAX_START - r;
                if ($urandom_range(0, 11) == 0) len = len + int'($urandom_range(0, 2)) - 1;
                if ($urandom_range(0, 40) == 0) len = 17 + int'($urandom_range(0, 3));
                p2 = ((MAX_START - r) == MIN_ROW);
                if ($urandom_range(0, 30) == 0) p2 = !p2;
                for (int k = 0; k < len; k++) begin
                    plan.push_back(($urandom_range(0, 199) == 0) ? 2'b01 : 2'b00);
                end
                plan.push_back({1'b1, p2});
            end
        end
        foreach (plan[i]) begin
            if ($urandom_range(0, 4) == 0) begin
                applyStimulus(1'b0, 1'($urandom), 1'($urandom));
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("[TB] FAIL random_idle_cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
                end
            end
            applyStimulus(1'b1, plan[i][1], plan[i][0]);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("[TB] FAIL random_cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        checks++;
        if (obs_n !== exp_n || obs_pd !== exp_pd || obs_sig !== exp_sig) begin
            errors++; $display("[TB] FAIL random_summary: got rows=%0d done=%0d expected rows=%0d done=%0d",
                               obs_n, obs_pd, exp_n, exp_pd);
        end
    endtask

    initial begin
        toggle_en = 0;
        tog_cnt   = 0;
        model_reset();
        clear_log();
        test_reset();
        test_clean();
        test_enable_toggle();
        test_short_row();
        test_bad_pulse2();
        test_gap_overflow();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
